// File: rtl/conv_accumulator_if.sv
// Purpose: term-in / result-out bundle between the multiplier, accumulator and feature-map writer.
// Latency: none (wires only).
// Backpressure: in_ready stalls the producer; out_ready stalls the result.
interface conv_accumulator_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_product;
    logic [WIDTH-1:0] bias;
    logic             relu_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;

    // Producer/consumer side: drives terms and out_ready, observes results.
    modport master (
        output in_valid, in_product, bias, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_product, bias, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/conv_accumulator.sv
// Purpose: sums KERNEL_LEN Q8.8 products plus a per-window bias, saturates, optional ReLU.
// Latency: last term accepted in cycle t -> out_valid high in cycle t+2.
// Backpressure: in_ready is low outside ACCUM; the result is held while out_ready is low.
module conv_accumulator #(
    parameter int WIDTH      = 16,
    parameter int DECIMAL    = 8,
    parameter int KERNEL_LEN = 9,
    parameter int GUARD      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_accumulator_if.slave    bus
);
    localparam int ACC_WIDTH = WIDTH + GUARD;
    localparam int SUM_WIDTH = ACC_WIDTH + 1;
    localparam int CNT_WIDTH = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

    localparam logic [CNT_WIDTH-1:0]        LAST_TERM = CNT_WIDTH'(KERNEL_LEN - 1);
    localparam logic signed [SUM_WIDTH-1:0] POS_MAX   = SUM_WIDTH'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] NEG_MIN   = SUM_WIDTH'(-(2 ** (WIDTH - 1)));

    // Guard bits must cover the worst-case growth of KERNEL_LEN terms; the Q point must fit.
    if (KERNEL_LEN < 1 || KERNEL_LEN > 2 ** GUARD || DECIMAL >= WIDTH) begin : g_bad_params
        $error("conv_accumulator: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINISH = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [CNT_WIDTH-1:0]          count;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [WIDTH-1:0]              bias_q;
    logic                          relu_q;
    logic                          out_valid_q;
    logic [WIDTH-1:0]              out_data_q;
    logic                          out_sat_q;

    logic                          accept;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [SUM_WIDTH-1:0]   sum;
    logic [WIDTH-1:0]              clip_data;
    logic                          clip_sat;
    logic [WIDTH-1:0]              res_data;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    assign accept   = bus.in_valid & bus.in_ready;
    assign prod_ext = {{GUARD{bus.in_product[WIDTH-1]}}, bus.in_product};
    // One extra bit so adding the bias to a full guard-width sum can never wrap.
    assign sum      = {acc[ACC_WIDTH-1], acc} + {{(SUM_WIDTH - WIDTH){bias_q[WIDTH-1]}}, bias_q};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: window complete -> one finish cycle -> hold until the writer takes it.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && count == LAST_TERM) state_nxt = FINISH;
            FINISH:  state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Saturate to WIDTH bits first, then ReLU; the sat flag reflects the clamp only.
    always_comb begin
        clip_data = sum[WIDTH-1:0];
        clip_sat  = 1'b0;
        if (sum > POS_MAX) begin
            clip_data = {1'b0, {(WIDTH - 1){1'b1}}};
            clip_sat  = 1'b1;
        end else if (sum < NEG_MIN) begin
            clip_data = {1'b1, {(WIDTH - 1){1'b0}}};
            clip_sat  = 1'b1;
        end
        res_data = (relu_q && clip_data[WIDTH-1]) ? '0 : clip_data;
    end

    // Datapath: accumulate terms, latch per-window controls, register and hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            acc         <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (count == '0) begin
                            // First term restarts the sum and captures the window's controls.
                            acc    <= prod_ext;
                            bias_q <= bus.bias;
                            relu_q <= bus.relu_en;
                        end else begin
                            acc <= acc + prod_ext;
                        end
                        count <= (count == LAST_TERM) ? '0 : count + 1'b1;
                    end
                end
                FINISH: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= res_data;
                    out_sat_q   <= clip_sat;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= '0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: reset state, sums, saturation edges, ReLU,
// backpressure, input gaps with mid-window control changes, and mid-window reset.
module tb_conv_accumulator;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    conv_accumulator_if #(.WIDTH(16)) bus ();

    conv_accumulator #(
        .WIDTH(16), .DECIMAL(8), .KERNEL_LEN(9), .GUARD(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one term and hold it until accepted; returns #1 after the accepting edge.
    task automatic send_term(input logic [15:0] prod, input logic [15:0] b, input logic r);
        int waited;
        waited = 0;
        bus.in_valid   = 1'b1;
        bus.in_product = prod;
        bus.bias       = b;
        bus.relu_en    = r;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) check("accept_timeout", 16'd0, 16'd1);
        tick();
        bus.in_valid   = 1'b0;
        bus.in_product = 16'hDEAD;
    endtask

    // Nine terms base + i*step; controls change on later terms and must be ignored.
    task automatic send_window(input logic [15:0] base, input logic [15:0] step,
                               input logic [15:0] b, input logic r, input bit gaps);
        int gap_len[9] = '{0, 2, 1, 3, 0, 1, 0, 2, 1};
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                for (int g = 0; g < gap_len[i]; g++) begin
                    bus.bias    = 16'h8000;
                    bus.relu_en = ~r;
                    tick();
                end
            end
            send_term(base + 16'(i) * step, (i == 0) ? b : (16'h8000 ^ 16'(i)), (i == 0) ? r : ~r);
            if (i < 8) check("no_early_valid", {15'd0, bus.out_valid}, 16'd0);
        end
    endtask

    // Called #1 after the last accepting edge; checks exact t+2 latency and the result.
    task automatic expect_result(input string tag, input logic [15:0] exp_data, input logic exp_sat);
        check({tag, "_finish_valid"}, {15'd0, bus.out_valid}, 16'd0);
        check({tag, "_finish_rdy"},   {15'd0, bus.in_ready},  16'd0);
        tick();
        check({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
        check({tag, "_data"},  bus.out_data,           exp_data);
        check({tag, "_sat"},   {15'd0, bus.out_sat},   {15'd0, exp_sat});
        if (bus.out_ready) begin
            tick();
            check({tag, "_drain_valid"}, {15'd0, bus.out_valid}, 16'd0);
            check({tag, "_drain_rdy"},   {15'd0, bus.in_ready},  16'd1);
        end
    endtask

    initial begin
        logic [15:0] held;
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_product = 16'h0000;
        bus.bias       = 16'h0000;
        bus.relu_en    = 1'b0;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  {15'd0, bus.in_ready},  16'd1);
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_out_data",  bus.out_data,           16'h0000);
        check("rst_out_sat",   {15'd0, bus.out_sat},   16'd0);
        reset = 1'b0;
        tick();

        // 9 x 1.0 + 0.5
        send_window(16'h0100, 16'h0000, 16'h0080, 1'b0, 1'b0);
        expect_result("basic", 16'h0980, 1'b0);

        // Positive and negative saturation
        send_window(16'h7000, 16'h0000, 16'h7000, 1'b0, 1'b0);
        expect_result("sat_pos", 16'h7FFF, 1'b1);
        send_window(16'h9000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_result("sat_neg", 16'h8000, 1'b1);

        // Exactly at the limits: no saturation
        send_window(16'h0E00, 16'h0000, 16'h01FF, 1'b0, 1'b0);
        expect_result("edge_pos", 16'h7FFF, 1'b0);
        send_window(16'hF200, 16'h0000, 16'hFE00, 1'b0, 1'b0);
        expect_result("edge_neg", 16'h8000, 1'b0);

        // ReLU on and off for a negative sum; ReLU after negative saturation keeps sat
        send_window(16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_result("relu_on", 16'h0000, 1'b0);
        send_window(16'hFF00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_result("relu_off", 16'hF700, 1'b0);
        send_window(16'h9000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        expect_result("relu_sat", 16'h0000, 1'b1);

        // Backpressure: result held, terms offered meanwhile are not taken
        bus.out_ready = 1'b0;
        send_window(16'h0200, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_result("bp", 16'h1200, 1'b0);
        held           = bus.out_data;
        bus.in_valid   = 1'b1;
        bus.in_product = 16'h0500;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", {15'd0, bus.out_valid}, 16'd1);
            check("bp_hold_data",  bus.out_data,           held);
            check("bp_hold_rdy",   {15'd0, bus.in_ready},  16'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_release_rdy", {15'd0, bus.in_ready}, 16'd0);
        tick();
        check("bp_after_valid", {15'd0, bus.out_valid}, 16'd0);
        check("bp_after_rdy",   {15'd0, bus.in_ready},  16'd1);
        send_window(16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_result("bp_next", 16'h0900, 1'b0);

        // Gaps between terms, ramp 1.0..9.0, later bias/relu changes ignored
        send_window(16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1);
        expect_result("gaps", 16'h2D00, 1'b0);

        // Reset after 4 terms discards the partial window
        for (int i = 0; i < 4; i++) send_term(16'h0100, 16'h0300, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
        check("mid_rst_rdy",   {15'd0, bus.in_ready},  16'd1);
        send_window(16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_result("post_rst", 16'h0900, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
